// File: rtl/word_serializer_if.sv
// ---------------------------------------------------------------------------
// word_serializer_if
// Bundles the parallel word handshake and the serial output of the
// word_serializer.
//   din        : parallel word (W bits)
//   din_valid  : din holds a word
//   din_ready  : serializer can take a word this cycle
//   msb_first  : bit order for the word offered on din
//   sout       : serial bit (idle level when no word is shifting)
//   sout_valid : sout carries a data bit
//   word_done  : last bit of a word is on sout
//   busy       : shifter active or holding buffer full
// master = word producer / observer, slave = serializer.
// ---------------------------------------------------------------------------
interface word_serializer_if #(
  parameter int W = 32
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         msb_first;
  logic         sout;
  logic         sout_valid;
  logic         word_done;
  logic         busy;

  modport master (
    output din, din_valid, msb_first,
    input  din_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid, msb_first,
    output din_ready, sout, sout_valid, word_done, busy
  );
endinterface

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
// Parallel-in, serial-out stage. Accepts W-bit words on a valid/ready
// handshake and shifts them out one bit per clock on sout. A one-word
// holding register lets consecutive words stream without gap cycles.
// When nothing is shifting, sout sits at IDLE_BIT.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : word_serializer_if.slave (din/din_valid/din_ready/msb_first in,
//         sout/sout_valid/word_done/busy out)
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module word_serializer #(
  parameter int   W        = 32,
  parameter logic IDLE_BIT = 1'b0
) (
  input logic              clk,
  input logic              rst,
  word_serializer_if.slave bus
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  shreg_r, shreg_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          ord_r, ord_s;
  logic [W-1:0]  hold_r, hold_s;
  logic          hold_ord_r, hold_ord_s;
  logic          hold_full_r, hold_full_s;

  logic          sout_r, sout_valid_r, word_done_r, busy_r, din_ready_r;
  logic          sout_s;
  logic          xfer_s;
  logic [W-1:0]  shifted_s;

  // The presented bit always sits at the end of the register selected by
  // the latched order, so advancing means shifting toward that end.
  always_comb begin
    xfer_s = bus.din_valid && din_ready_r;
    if (ord_r) begin
      shifted_s = shreg_r << 1'b1;
    end else begin
      shifted_s = shreg_r >> 1'b1;
    end
  end

  // Next-state computation for shifter, counter and holding register.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    ord_s       = ord_r;
    hold_s      = hold_r;
    hold_ord_s  = hold_ord_r;
    hold_full_s = hold_full_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_s = ST_SHIFT;
          shreg_s = bus.din;
          ord_s   = bus.msb_first;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == LAST) begin
          // Last bit: a held word wins; din_ready is low then, so no
          // transfer can compete with it.
          if (hold_full_r) begin
            shreg_s     = hold_r;
            ord_s       = hold_ord_r;
            hold_full_s = 1'b0;
            cnt_s       = {CW{1'b0}};
          end else if (xfer_s) begin
            shreg_s = bus.din;
            ord_s   = bus.msb_first;
            cnt_s   = {CW{1'b0}};
          end else begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          cnt_s   = cnt_r + CW'(1);
          shreg_s = shifted_s;
          if (xfer_s) begin
            hold_s      = bus.din;
            hold_ord_s  = bus.msb_first;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = {CW{1'b0}};
        hold_full_s = 1'b0;
      end
    endcase
  end

  // Bit that will be on sout once the next state is registered.
  always_comb begin
    if (state_s == ST_SHIFT) begin
      if (ord_s) begin
        sout_s = shreg_s[W-1];
      end else begin
        sout_s = shreg_s[0];
      end
    end else begin
      sout_s = IDLE_BIT;
    end
  end

  // State and output registers; outputs are computed from next state so
  // they line up with the bit being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {W{1'b0}};
      cnt_r        <= {CW{1'b0}};
      ord_r        <= 1'b0;
      hold_r       <= {W{1'b0}};
      hold_ord_r   <= 1'b0;
      hold_full_r  <= 1'b0;
      sout_r       <= IDLE_BIT;
      sout_valid_r <= 1'b0;
      word_done_r  <= 1'b0;
      busy_r       <= 1'b0;
      din_ready_r  <= 1'b1;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      cnt_r        <= cnt_s;
      ord_r        <= ord_s;
      hold_r       <= hold_s;
      hold_ord_r   <= hold_ord_s;
      hold_full_r  <= hold_full_s;
      sout_r       <= sout_s;
      sout_valid_r <= (state_s == ST_SHIFT);
      word_done_r  <= (state_s == ST_SHIFT) && (cnt_s == LAST);
      busy_r       <= (state_s == ST_SHIFT) || hold_full_s;
      din_ready_r  <= !hold_full_s;
    end
  end

  assign bus.sout       = sout_r;
  assign bus.sout_valid = sout_valid_r;
  assign bus.word_done  = word_done_r;
  assign bus.busy       = busy_r;
  assign bus.din_ready  = din_ready_r;

endmodule

// File: tb/tb_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_serializer
// Bench for word_serializer with W=8. The reference is a FIFO of at most
// two words in flight plus the position inside the head word; outputs
// are derived from that every cycle. Directed cases pin the model with
// literal bit streams.
// ---------------------------------------------------------------------------
module tb_word_serializer;

  localparam int W = 8;

  logic clk;
  logic rst;
  word_serializer_if #(.W(W)) bus ();

  word_serializer #(.W(W), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model: words in flight, head word position
  logic [W-1:0] mq_w[$];
  logic         mq_o[$];
  int           mpos = 0;
  logic         last_acc = 1'b0;
  logic         chk_en = 1'b0;

  // observations
  logic obs[$];
  int   done_pos[$];
  int   runs = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model across one rising edge using the pre-edge inputs
  task automatic model_edge();
    logic acc;
    acc = 1'b0;
    if (rst) begin
      mq_w.delete();
      mq_o.delete();
      mpos = 0;
    end else begin
      acc = bus.din_valid && (mq_w.size() < 2);
      if (mq_w.size() > 0) begin
        mpos++;
        if (mpos == W) begin
          void'(mq_w.pop_front());
          void'(mq_o.pop_front());
          mpos = 0;
        end
      end
      if (acc) begin
        mq_w.push_back(bus.din);
        mq_o.push_back(bus.msb_first);
      end
    end
    last_acc = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic       e_valid, e_sout, e_done, e_busy, e_ready;
    logic [W-1:0] hw;
    if (chk_en) begin
      e_valid = (mq_w.size() > 0);
      e_sout  = 1'b0;
      e_done  = 1'b0;
      if (e_valid) begin
        hw     = mq_w[0];
        e_sout = mq_o[0] ? hw[W-1-mpos] : hw[mpos];
        e_done = (mpos == W - 1);
      end
      e_busy  = e_valid;
      e_ready = (mq_w.size() < 2);
      check("sout",       {31'd0, bus.sout},       {31'd0, e_sout});
      check("sout_valid", {31'd0, bus.sout_valid}, {31'd0, e_valid});
      check("word_done",  {31'd0, bus.word_done},  {31'd0, e_done});
      check("busy",       {31'd0, bus.busy},       {31'd0, e_busy});
      check("din_ready",  {31'd0, bus.din_ready},  {31'd0, e_ready});
      if (bus.sout_valid === 1'b1) begin
        obs.push_back(bus.sout);
        if (prev_valid !== 1'b1) runs++;
      end
      if (bus.word_done === 1'b1) done_pos.push_back(obs.size());
      prev_valid = bus.sout_valid;
    end
  end

  function automatic logic [15:0] pack_obs();
    logic [15:0] v;
    v = 16'd0;
    foreach (obs[i]) v = {v[14:0], obs[i]};
    return v;
  endfunction

  task automatic clear_obs();
    obs.delete();
    done_pos.delete();
    runs = 0;
  endtask

  task automatic send_two(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, output int n_acc);
    n_acc = 0;
    bus.msb_first = m;
    bus.din       = a;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      tick();
      if (last_acc) begin
        n_acc++;
        bus.din = b;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  initial begin
    int n_acc;
    rst           = 1'b1;
    bus.din       = 8'hFF;
    bus.din_valid = 1'b1;
    bus.msb_first = 1'b1;

    // reset with din_valid asserted
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_din_ready",  {31'd0, bus.din_ready},  32'd1);
    check("rst_sout",       {31'd0, bus.sout},       32'd0);
    check("rst_sout_valid", {31'd0, bus.sout_valid}, 32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_word_done",  {31'd0, bus.word_done},  32'd0);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    clear_obs();
    repeat (3) tick();
    check("rst_no_accept", obs.size(), 32'd0);

    // MSB-first single word
    clear_obs();
    bus.din = 8'hB4; bus.msb_first = 1'b1; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (11) tick();
    check("msb_len",  obs.size(), 32'd8);
    check("msb_bits", {16'd0, pack_obs()}, 32'h0000_00B4);
    check("msb_done_n", done_pos.size(), 32'd1);
    if (done_pos.size() > 0) check("msb_done_pos", done_pos[0], 32'd8);
    check("msb_idle_sout", {31'd0, bus.sout}, 32'd0);

    // LSB-first single word: 0,0,1,0,1,1,0,1
    clear_obs();
    bus.din = 8'hB4; bus.msb_first = 1'b0; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (11) tick();
    check("lsb_len",  obs.size(), 32'd8);
    check("lsb_bits", {16'd0, pack_obs()}, 32'h0000_002D);

    // back-to-back with the second word held
    clear_obs();
    send_two(8'h0F, 8'hF0, 1'b1, n_acc);
    check("b2b_accepts",   n_acc, 32'd2);
    check("b2b_hold_ready", {31'd0, bus.din_ready}, 32'd0);
    check("b2b_hold_busy",  {31'd0, bus.busy},      32'd1);
    repeat (20) tick();
    check("b2b_len",  obs.size(), 32'd16);
    check("b2b_bits", {16'd0, pack_obs()}, 32'h0000_0FF0);
    check("b2b_runs", runs, 32'd1);
    check("b2b_done_n", done_pos.size(), 32'd2);
    if (done_pos.size() == 2) begin
      check("b2b_done0", done_pos[0], 32'd8);
      check("b2b_done1", done_pos[1], 32'd16);
    end

    // second word offered only during the last bit of the first
    clear_obs();
    bus.din = 8'hA5; bus.msb_first = 1'b1; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (7) tick();
    bus.din = 8'h3C; bus.msb_first = 1'b0; bus.din_valid = 1'b1;
    tick();
    check("lastbit_accept", {31'd0, last_acc}, 32'd1);
    bus.din_valid = 1'b0;
    repeat (12) tick();
    check("lastbit_len",  obs.size(), 32'd16);
    check("lastbit_bits", {16'd0, pack_obs()}, 32'h0000_A53C);
    check("lastbit_runs", runs, 32'd1);

    // reset at bit 3 of word 1 with word 2 held
    clear_obs();
    send_two(8'h0F, 8'hF0, 1'b1, n_acc);
    check("mid_accepts", n_acc, 32'd2);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("mid_sout_valid", {31'd0, bus.sout_valid}, 32'd0);
    check("mid_busy",       {31'd0, bus.busy},       32'd0);
    check("mid_din_ready",  {31'd0, bus.din_ready},  32'd1);
    rst = 1'b0;
    repeat (20) tick();
    check("mid_bits_seen", obs.size(), 32'd4);
    check("mid_no_done",   done_pos.size(), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 249) == 0);
      bus.din_valid = ($urandom_range(0, 3) != 0);
      bus.din       = W'($urandom);
      bus.msb_first = $urandom_range(0, 1) == 1;
      tick();
    end
    rst = 1'b0;
    bus.din_valid = 1'b0;
    repeat (20) tick();
    check("drain_idle", {31'd0, bus.sout_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

- Parallel-in, serial-out stage that feeds the serial bit-pattern detector.
- Accepts W-bit words on a valid/ready handshake and emits them one bit per clock on `sout`.
- A one-word holding buffer lets back-to-back words stream with no gap cycles.
- During gaps `sout` is driven to a fixed idle level, so the downstream detector sees a defined bit every cycle.

## Interface

- `W`, 32: word width in bits; legal range 1..32.
- `IDLE_BIT`, 1'b0: level driven on `sout` whenever no word is being shifted.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `din` input W: parallel word.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: block can take a word this cycle.
- `msb_first` input 1: bit order, sampled with the word at acceptance; 1 = bit W-1 first, 0 = bit 0 first.
- `sout` output 1: serial bit; registered; connects to the detector data input.
- `sout_valid` output 1: `sout` carries a data bit, not the idle level.
- `word_done` output 1: high in the cycle the last bit of a word is on `sout`.
- `busy` output 1: shifter active or holding buffer full.

## Operation

- Storage:
  - shift register plus its bit counter (0..W-1) and latched order bit;
  - holding register with a `hold_full` flag and its latched order bit.
- FSM states:
  - IDLE: shifter empty; `sout`=IDLE_BIT; `sout_valid`=0.
  - SHIFT: shifter presenting bit number `cnt`.
- Handshake:
  - `din_ready` = !`hold_full`. This is registered state, with no combinational path from `din_valid`.
  - A transfer occurs on a rising edge where `din_valid` && `din_ready` are both high.
  - `din` and `msb_first` are captured only on a transfer.
- Routing of an accepted word:
  - IDLE: loads straight into the shifter; next state SHIFT, `cnt`=0.
  - SHIFT with `cnt`<W-1: goes to the holding register; `hold_full` is set.
  - SHIFT with `cnt`=W-1 and hold empty: loads straight into the shifter, `cnt`=0. Next word follows with no gap.
- At the last bit (SHIFT, `cnt`=W-1), in priority order:
  - hold full: hold contents and order bit move into the shifter; `hold_full` clears; `cnt`=0.
  - else a transfer occurs: load as above.
  - else: go to IDLE.
- Otherwise in SHIFT, `cnt` increments and the register shifts one position in the latched order.
- Bit order:
  - `msb_first`=1: bit k of the output stream is word bit W-1-k.
  - `msb_first`=0: bit k of the output stream is word bit k.
- W=1: every bit is a last bit. Words accepted every cycle stream continuously, and `word_done` is high every cycle.
- Reset (any time, including mid-word):
  - FSM to IDLE, `cnt`=0, `hold_full`=0;
  - shifter and hold contents are discarded with no partial-word indication.

## Timing

- Reset values: `sout`=IDLE_BIT, `sout_valid`=0, `word_done`=0, `busy`=0, `din_ready`=1.
- Latency: a word accepted at edge k while IDLE has its first bit on `sout` in the cycle after edge k, with `sout_valid`=1.
- A word occupies exactly W consecutive cycles of `sout_valid`=1.
- `word_done` is high for exactly one cycle per word, the cycle its bit W-1 of the stream is on `sout`.
- Back-to-back streaming:
  - The first bit of the next word appears the cycle after the previous `word_done`, provided the next word was held or was accepted by the last-bit edge.
  - Sustained throughput is one word per W cycles.
- Buffering:
  - At most two words are in flight (shifter + hold).
  - `din_ready` falls the cycle after the hold fills and rises the cycle after hold moves to the shifter.
- `busy` = (state==SHIFT) || `hold_full`, registered-state derived.

## Test plan

- **Reset values:** hold `rst`=1 for 2 cycles with `din_valid`=1 → `din_ready`=1, `sout`=0, `sout_valid`=0, `busy`=0; no word accepted.
- **MSB-first single word:** W=8, `din`=8'hB4, `msb_first`=1, one transfer.
  - `sout` sequence is 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting the cycle after the transfer.
  - `word_done` is high on the 8th bit only; then `sout_valid`=0 and `sout`=0.
- **LSB-first single word:** W=8, `din`=8'hB4, `msb_first`=0 → `sout` sequence is 0,0,1,0,1,1,0,1.
- **Back-to-back with hold:** W=8, `din_valid` held high with words 8'h0F then 8'hF0, `msb_first`=1.
  - Second word sits in hold; `din_ready`=0 while hold is full.
  - 16 consecutive valid bits 0000111111110000; `word_done` high at bits 8 and 16.
  - Downstream detector output goes high after the 3rd zero and the 3rd one.
- **Last-bit direct load:** offer the second word only in the cycle `cnt`=7 → no gap cycle; `sout_valid` is continuous across the word boundary.
- **Reset mid-operation:** assert `rst` at bit 3 of word 1 with word 2 held.
  - Next cycle: `sout_valid`=0, `busy`=0, `din_ready`=1.
  - No further bits from either word appear.
